// File: rtl/laplace_window_gen_pkg.sv
// rtl/laplace_window_gen_pkg.sv - shared defaults and helpers for the Laplace window generator
// Purpose: default pixel width and frame geometry shared with the laplace9_* kernel
//          stages, plus a counter-width helper used by the generator and its line buffers.
// Ports:   none (package).
package laplace_window_gen_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/laplace_window_gen_if.sv
// rtl/laplace_window_gen_if.sv - pixel-in / cross-window-out stream bundle
// Purpose: groups the input pixel handshake and the output window handshake.
// Ports:   in_valid/in_ready/in_sof/in_pixel  - raster pixel stream into the generator
//          out_valid/out_ready/out_b..out_h/out_eof - cross window stream out of it
//          modport slave  - generator side
//          modport master - source/sink side
interface laplace_window_gen_if
  import laplace_window_gen_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_b;
  logic [PIX_W-1:0] out_d;
  logic [PIX_W-1:0] out_e;
  logic [PIX_W-1:0] out_f;
  logic [PIX_W-1:0] out_h;
  logic             out_eof;

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, out_b, out_d, out_e, out_f, out_h, out_eof
  );

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, out_b, out_d, out_e, out_f, out_h, out_eof
  );
endinterface

// File: rtl/laplace_window_gen_line_buffer.sv
// rtl/laplace_window_gen_line_buffer.sv - one image row of pixel storage
// Purpose: DEPTH x WIDTH row store with asynchronous read and synchronous write at the
//          same address; a read in the write cycle returns the old contents.
// Ports:   clk   - clock
//          we    - write enable
//          addr  - shared read/write column address
//          wdata - data written on we
//          rdata - current contents at addr
module laplace_window_gen_line_buffer
  import laplace_window_gen_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = PIX_W_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [cnt_w(DEPTH)-1:0]   addr,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata
);

  // Row contents are deliberately not reset: every row is rewritten before it is read.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/laplace_window_gen.sv
// rtl/laplace_window_gen.sv - streaming 5-point cross window generator
// Purpose: takes raster-order pixels and, for every interior centre, emits the cross
//          window b (up), d (left), e (centre), f (right), h (down) one cycle after the
//          pixel that completes it. Border centres produce nothing.
// Ports:   clk   - clock, rising edge
//          rst_n - asynchronous active-low reset
//          bus   - laplace_window_gen_if.slave: pixel input and window output handshakes
module laplace_window_gen
  import laplace_window_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  laplace_window_gen_if.slave  bus
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d, pos_col;
  logic [RW-1:0]    row_q, row_d, pos_row;
  logic             in_ready, accept, fire;
  logic [PIX_W-1:0] top_rd, mid_rd;

  // Column history. The live column (top_rd, mid_rd, in_pixel) is the newest stage;
  // only the registered taps that feed the cross are kept (corners are never used).
  logic [PIX_W-1:0]          top_sr_q, top_sr_d;
  logic [1:0][PIX_W-1:0]     mid_sr_q, mid_sr_d;
  logic [PIX_W-1:0]          cur_sr_q, cur_sr_d;

  logic             out_valid_q, out_valid_d;
  logic             out_eof_q, out_eof_d;
  logic [PIX_W-1:0] out_b_q, out_b_d, out_d_q, out_d_d, out_e_q, out_e_d;
  logic [PIX_W-1:0] out_f_q, out_f_d, out_h_q, out_h_d;

  laplace_window_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_col),
    .wdata (bus.in_pixel),
    .rdata (mid_rd)
  );

  // LB2 inherits what LB1 held for this column, so it always trails by one row.
  laplace_window_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_col),
    .wdata (mid_rd),
    .rdata (top_rd)
  );

  always_comb begin
    in_ready    = !out_valid_q || bus.out_ready;
    accept      = bus.in_valid && in_ready;
    // Start-of-frame pins the accepted pixel to (0,0) regardless of the counters.
    pos_col     = bus.in_sof ? '0 : col_q;
    pos_row     = bus.in_sof ? '0 : row_q;
    // Needing two earlier columns and two earlier rows also guarantees that stale
    // history from the previous row is never emitted.
    fire        = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));

    col_d       = col_q;
    row_d       = row_q;
    top_sr_d    = top_sr_q;
    mid_sr_d    = mid_sr_q;
    cur_sr_d    = cur_sr_q;
    out_valid_d = out_valid_q;
    out_eof_d   = out_eof_q;
    out_b_d     = out_b_q;
    out_d_d     = out_d_q;
    out_e_d     = out_e_q;
    out_f_d     = out_f_q;
    out_h_d     = out_h_q;

    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      top_sr_d = top_rd;
      mid_sr_d = {mid_sr_q[0], mid_rd};
      cur_sr_d = bus.in_pixel;
    end

    // A new window may overwrite one being taken this cycle, so the load wins.
    if (fire) begin
      out_valid_d = 1'b1;
      out_b_d     = top_sr_q;
      out_d_d     = mid_sr_q[1];
      out_e_d     = mid_sr_q[0];
      out_f_d     = mid_rd;
      out_h_d     = cur_sr_q;
      out_eof_d   = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      top_sr_q    <= '0;
      mid_sr_q    <= '0;
      cur_sr_q    <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_b_q     <= '0;
      out_d_q     <= '0;
      out_e_q     <= '0;
      out_f_q     <= '0;
      out_h_q     <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      top_sr_q    <= top_sr_d;
      mid_sr_q    <= mid_sr_d;
      cur_sr_q    <= cur_sr_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      out_b_q     <= out_b_d;
      out_d_q     <= out_d_d;
      out_e_q     <= out_e_d;
      out_f_q     <= out_f_d;
      out_h_q     <= out_h_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_d     = out_d_q;
  assign bus.out_e     = out_e_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_h     = out_h_q;

endmodule

// File: tb/tb_laplace_window_gen.sv
// tb/tb_laplace_window_gen.sv - self-checking bench for laplace_window_gen
module tb_laplace_window_gen;

  localparam int BW = 40;
  localparam int BH = 30;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] f;
    logic [7:0] h;
    logic       eof;
  } win_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  laplace_window_gen_if #(.PIX_W(8)) if4 ();
  laplace_window_gen_if #(.PIX_W(8)) ifb ();

  laplace_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  laplace_window_gen #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8)) dutb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] pix_q [$];
  bit         sof_q [$];
  bit         trig_q[$];
  win_t       exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic s, input logic [7:0] p,
                       input logic r);
    if (sel) begin
      ifb.in_valid = v; ifb.in_sof = s; ifb.in_pixel = p; ifb.out_ready = r;
    end else begin
      if4.in_valid = v; if4.in_sof = s; if4.in_pixel = p; if4.out_ready = r;
    end
  endtask

  task automatic sample(input bit sel, output logic ov, output logic ir, output win_t w);
    if (sel) begin
      ov = ifb.out_valid; ir = ifb.in_ready;
      w  = '{ifb.out_b, ifb.out_d, ifb.out_e, ifb.out_f, ifb.out_h, ifb.out_eof};
    end else begin
      ov = if4.out_valid; ir = if4.in_ready;
      w  = '{if4.out_b, if4.out_d, if4.out_e, if4.out_f, if4.out_h, if4.out_eof};
    end
  endtask

  // Reference: a w x h frame; only the first npix pixels are streamed, and a window
  // centred at (r,c) exists only if its completing pixel (r+1,c+1) is among them.
  task automatic add_frame(input int w, input int h, input int npix, input int base,
                           input bit rnd, input bit sof);
    int fr[];
    fr = new[w * h];
    for (int i = 0; i < w * h; i++)
      fr[i] = rnd ? int'($urandom_range(0, 255)) : ((base + i) & 255);
    for (int i = 0; i < npix; i++) begin
      pix_q.push_back(8'(fr[i]));
      sof_q.push_back(sof && (i == 0));
      trig_q.push_back((i / w >= 2) && (i % w >= 2));
    end
    for (int r = 1; r < h - 1; r++)
      for (int c = 1; c < w - 1; c++)
        if ((r + 1) * w + c + 1 < npix)
          exp_q.push_back('{8'(fr[(r-1)*w+c]), 8'(fr[r*w+c-1]), 8'(fr[r*w+c]),
                            8'(fr[r*w+c+1]), 8'(fr[(r+1)*w+c]),
                            (r == h - 2) && (c == w - 2)});
  endtask

  // mode 0: out_ready always 1; 1: random; 2: stall 3 cycles on the second window.
  task automatic run(input bit sel, input int mode, input bit gaps,
                     output int got, output int eofs);
    logic ov, ir;
    win_t w, held, ew;
    bit   held_v, exp_ov, rdy, vld, t;
    int   cyc, stall;
    got = 0; eofs = 0; held_v = 0; exp_ov = 0; cyc = 0; stall = 0; held = '0;
    while ((pix_q.size() != 0 || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      sample(sel, ov, ir, w);
      chk("out_valid", 64'(ov), 64'(exp_ov));
      if (held_v) chk("held_window", 64'(w), 64'(held));
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(ov && got == 1 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      vld = (pix_q.size() != 0) && (!gaps || $urandom_range(0, 3) != 0);
      if (vld) drive(sel, 1'b1, sof_q[0], pix_q[0], rdy);
      else     drive(sel, 1'b0, 1'b0, 8'h00, rdy);
      #1;
      sample(sel, ov, ir, w);
      chk("in_ready", 64'(ir), 64'(!exp_ov || rdy));
      if (ov && rdy) begin
        if (exp_q.size() == 0) chk("spurious_window", 64'(ov), 64'd0);
        else begin
          ew = exp_q.pop_front();
          chk("window", 64'(w), 64'(ew));
          got++;
          eofs += int'(w.eof);
        end
      end
      held_v = ov && !rdy;
      held   = w;
      t = 1'b0;
      if (vld && ir) begin
        t = trig_q.pop_front();
        void'(pix_q.pop_front());
        void'(sof_q.pop_front());
      end
      exp_ov = t ? 1'b1 : (rdy ? 1'b0 : exp_ov);
    end
    drive(sel, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("stream_drained", 64'(pix_q.size() + exp_q.size()), 64'd0);
    if (mode == 2) chk("stall_cycles", 64'(stall), 64'd3);
    @(negedge clk);
    sample(sel, ov, ir, w);
    chk("idle_after_run", 64'(ov), 64'd0);
  endtask

  initial begin
    int   got, eofs;
    logic ov, ir;
    win_t w;

    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sample(1'b0, ov, ir, w);
    chk("reset_out_valid", 64'(ov), 64'd0);
    chk("reset_in_ready", 64'(ir), 64'd1);
    chk("reset_window", 64'(w), 64'd0);
    sample(1'b1, ov, ir, w);
    chk("reset_out_valid_big", 64'(ov), 64'd0);
    rst_n = 1'b1;

    // Single 4x4 frame, p = 4r + c, free-flowing.
    add_frame(4, 4, 16, 0, 1'b0, 1'b1);
    run(1'b0, 0, 1'b0, got, eofs);
    chk("frame1_count", 64'(got), 64'd4);
    chk("frame1_eof_count", 64'(eofs), 64'd1);

    // Same frame with a 3-cycle stall on the second window.
    add_frame(4, 4, 16, 0, 1'b0, 1'b1);
    run(1'b0, 2, 1'b0, got, eofs);
    chk("stall_count", 64'(got), 64'd4);

    // Two back-to-back frames, each opened by in_sof.
    add_frame(4, 4, 16, 0, 1'b0, 1'b1);
    add_frame(4, 4, 16, 100, 1'b0, 1'b1);
    run(1'b0, 0, 1'b0, got, eofs);
    chk("b2b_count", 64'(got), 64'd8);
    chk("b2b_eof_count", 64'(eofs), 64'd2);

    // Frame abandoned after (2,0); in_sof lands where (2,1) would have been.
    add_frame(4, 4, 9, 50, 1'b0, 1'b1);
    add_frame(4, 4, 16, 0, 1'b0, 1'b1);
    run(1'b0, 0, 1'b0, got, eofs);
    chk("restart_count", 64'(got), 64'd4);

    // Reset while the first window is being presented.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, i == 0, 8'(i), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    sample(1'b0, ov, ir, w);
    chk("pre_reset_valid", 64'(ov), 64'd1);
    chk("pre_reset_window", 64'(w), 64'({8'd1, 8'd4, 8'd5, 8'd6, 8'd9, 1'b0}));
    #1 rst_n = 1'b0;
    #1;
    sample(1'b0, ov, ir, w);
    chk("async_reset_valid", 64'(ov), 64'd0);
    chk("async_reset_ready", 64'(ir), 64'd1);
    chk("async_reset_window", 64'(w), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    add_frame(4, 4, 16, 0, 1'b0, 1'b0);
    run(1'b0, 0, 1'b0, got, eofs);
    chk("post_reset_count", 64'(got), 64'd4);
    chk("post_reset_eof_count", 64'(eofs), 64'd1);

    // Larger geometry: two random frames, random gaps and back-pressure.
    add_frame(BW, BH, BW * BH, 0, 1'b1, 1'b1);
    add_frame(BW, BH, BW * BH, 0, 1'b1, 1'b0);
    run(1'b1, 1, 1'b1, got, eofs);
    chk("random_count", 64'(got), 64'(2 * (BW - 2) * (BH - 2)));
    chk("random_eof_count", 64'(eofs), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
